vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 202 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters issue pixel requests
// PREFETCH ce-cycles ahead of a registered display stage (syncs, de, pixel mux).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_W    = 12,
  parameter int PREFETCH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [9:0]       req_x,
  output logic [9:0]       req_y,
  output logic             req_valid,
  output logic [PIX_W-1:0] pixel_out,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int   HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   CW     = PIX_W / 3;
  localparam int   H_SS   = H_ACTIVE + H_FP;
  localparam int   H_SE   = H_SS + H_SYNC;
  localparam int   V_SS   = V_ACTIVE + V_FP;
  localparam int   V_SE   = V_SS + V_SYNC;
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [1:0]       mode_q, mode_use_s;
  logic [9:0]       dh_s, dv_s;
  logic             dval_s;
  logic [2:0]       bar_idx_s, bar_val_s;
  logic             act_s, border_s;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic [7:0]       fcnt_q, fcnt_d;

  // Raster counter next state: h wraps at end of line, v at end of frame
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == 10'(HT - 1)) begin
      h_d = 10'd0;
      if (v_q == 10'(VT - 1)) begin
        v_d = 10'd0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  // Raster counters and frame-aligned mode latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q    <= 10'd0;
      v_q    <= 10'd0;
      mode_q <= 2'd0;
    end else if (ce) begin
      h_q <= h_d;
      v_q <= v_d;
      if (h_q == 10'd0 && v_q == 10'd0) begin
        mode_q <= mode;
      end
    end
  end

  assign req_x     = h_q;
  assign req_y     = v_q;
  assign req_valid = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));

  // Valid flags keep the reset-cleared stages from emitting a bogus (0,0)
  if (PREFETCH == 0) begin : g_nopipe
    assign dh_s   = h_q;
    assign dv_s   = v_q;
    assign dval_s = 1'b1;
  end else begin : g_pipe
    logic [9:0]          ph_q [PREFETCH];
    logic [9:0]          pv_q [PREFETCH];
    logic [PREFETCH-1:0] pval_q;

    // Position delay line between request and display
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < PREFETCH; i++) begin
          ph_q[i] <= 10'd0;
          pv_q[i] <= 10'd0;
        end
        pval_q <= {PREFETCH{1'b0}};
      end else if (ce) begin
        ph_q[0]   <= h_q;
        pv_q[0]   <= v_q;
        pval_q[0] <= 1'b1;
        for (int i = 1; i < PREFETCH; i++) begin
          ph_q[i]   <= ph_q[i-1];
          pv_q[i]   <= pv_q[i-1];
          pval_q[i] <= pval_q[i-1];
        end
      end
    end

    assign dh_s   = ph_q[PREFETCH-1];
    assign dv_s   = pv_q[PREFETCH-1];
    assign dval_s = pval_q[PREFETCH-1];
  end

  // Without prefetch the (0,0) pixel is displayed on the same edge that latches mode
  assign mode_use_s = (PREFETCH == 0 && h_q == 10'd0 && v_q == 10'd0) ? mode : mode_q;
  assign bar_idx_s  = 3'(({dh_s, 3'b000}) / 13'(H_ACTIVE));
  assign bar_val_s  = 3'd7 - bar_idx_s;

  // Display-stage next values from the delayed position
  always_comb begin
    act_s    = dval_s && (dh_s < 10'(H_ACTIVE)) && (dv_s < 10'(V_ACTIVE));
    border_s = (dh_s == 10'd0) || (dh_s == 10'(H_ACTIVE - 1)) ||
               (dv_s == 10'd0) || (dv_s == 10'(V_ACTIVE - 1));
    pix_d    = {PIX_W{1'b0}};
    if (act_s) begin
      case (mode_use_s)
        2'd0: pix_d = pixel_in;
        2'd1: pix_d = {{CW{bar_val_s[2]}}, {CW{bar_val_s[1]}}, {CW{bar_val_s[0]}}};
        2'd2: begin
          if (border_s) begin
            pix_d = {PIX_W{1'b1}};
          end else begin
            pix_d = pixel_in;
          end
        end
        2'd3: pix_d = {PIX_W{1'b1}};
        default: pix_d = {PIX_W{1'b0}};
      endcase
    end else begin
      pix_d = {PIX_W{1'b0}};
    end
    if (dval_s && dh_s >= 10'(H_SS) && dh_s < 10'(H_SE)) begin
      hs_d = HS_ACT;
    end else begin
      hs_d = ~HS_ACT;
    end
    if (dval_s && dv_s >= 10'(V_SS) && dv_s < 10'(V_SE)) begin
      vs_d = VS_ACT;
    end else begin
      vs_d = ~VS_ACT;
    end
    de_d = act_s;
    ls_d = dval_s && (dh_s == 10'd0);
    fs_d = ls_d && (dv_s == 10'd0);
    if (fs_d) begin
      fcnt_d = fcnt_q + 8'd1;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q  <= {PIX_W{1'b0}};
      hs_q   <= ~HS_ACT;
      vs_q   <= ~VS_ACT;
      de_q   <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      fcnt_q <= 8'd0;
    end else if (ce) begin
      pix_q  <= pix_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign pixel_out   = pix_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (24x13 total, 16x8 active, PREFETCH=2).
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 3, HT = HA + HFP + HS + HB;
  localparam int VA = 8, VFP = 1, VS = 2, VB = 2, VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;
  localparam int P  = 2;

  logic        clk = 1'b0;
  logic        rst, ce, zero_pix;
  logic [1:0]  mode;
  logic [11:0] pixel_in, d1, d2;
  logic [9:0]  req_x, req_y;
  logic        req_valid, hsync, vsync, de, line_start, frame_start;
  logic [11:0] pixel_out;
  logic [7:0]  frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  int per, low, decnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .PIX_W(12), .PREFETCH(P)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .pixel_in(pixel_in),
    .req_x(req_x), .req_y(req_y), .req_valid(req_valid), .pixel_out(pixel_out),
    .hsync(hsync), .vsync(vsync), .de(de), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Pixel source returning {y[3:0], x[7:0]} PREFETCH ce-cycles after the request
  initial begin
    d1 = 12'd0;
    d2 = 12'd0;
  end
  always @(posedge clk) begin
    if (ce) begin
      d1 <= {req_y[3:0], req_x[7:0]};
      d2 <= d1;
    end
  end
  assign pixel_in = zero_pix ? 12'd0 : d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (ce) edges++;
    #1;
  endtask

  function automatic int disp(input int x, input int y, input int f);
    return P + 1 + f * FT + y * HT + x;
  endfunction

  task automatic goto(input int t);
    ce = 1'b1;
    while (edges < t) tick();
  endtask

  // Measures one period of hsync (sel=0) or vsync (sel=1) with ce high 1-in-div
  task automatic measure(input int sel, input int div, output int o_per, output int o_low,
                         output int o_de);
    int t1, t2;
    logic prev, s;
    t1 = -1; t2 = -1; o_low = 0; o_de = 0;
    prev = (sel != 0) ? vsync : hsync;
    for (int c = 0; c < 4 * FT * div && t2 < 0; c++) begin
      ce = ((c % div) == 0);
      tick();
      s = (sel != 0) ? vsync : hsync;
      if (prev && !s) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
      if (t1 >= 0 && t2 < 0) begin
        if (!s) o_low++;
        if (de) o_de++;
      end
      prev = s;
    end
    o_per = (t2 < 0) ? -1 : t2 - t1;
    ce = 1'b1;
  endtask

  initial begin
    int t;
    rst = 1'b0; ce = 1'b1; mode = 2'd0; zero_pix = 1'b0;
    repeat (3) tick();
    chk("rst_pix", pixel_out, 12'h000);
    chk("rst_de", de, 1'b0);
    chk("rst_hs", hsync, 1'b1);
    chk("rst_vs", vsync, 1'b1);
    chk("rst_ls", line_start, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_fcnt", frame_cnt, 8'd0);
    chk("rst_reqx", req_x, 10'd0);
    chk("rst_reqv", req_valid, 1'b1);

    rst = 1'b1; edges = 0;
    tick();
    chk("e1_fs", frame_start, 1'b0);
    chk("e1_reqx", req_x, 10'd1);
    tick();
    chk("e2_fs", frame_start, 1'b0);
    tick();
    chk("e3_fs", frame_start, 1'b1);
    chk("e3_ls", line_start, 1'b1);
    chk("e3_fcnt", frame_cnt, 8'd1);
    chk("e3_de", de, 1'b1);
    tick();
    chk("e4_fs", frame_start, 1'b0);
    chk("e4_ls", line_start, 1'b0);

    // frame 0, mode 0: pass-through and horizontal timing
    goto(disp(5, 3, 0));  chk("f0_pix53", pixel_out, 12'h305);
    goto(disp(16, 3, 0)); chk("f0_de16", de, 1'b0); chk("f0_pix16", pixel_out, 12'h000);
    goto(disp(17, 3, 0)); chk("f0_hs17", hsync, 1'b1);
    goto(disp(18, 3, 0)); chk("f0_hs18", hsync, 1'b0);
    goto(disp(20, 3, 0)); chk("f0_hs20", hsync, 1'b0);
    goto(disp(21, 3, 0)); chk("f0_hs21", hsync, 1'b1);
    goto(disp(0, 4, 0));  chk("f0_ls4", line_start, 1'b1); chk("f0_fs4", frame_start, 1'b0);
    mode = 2'd1;
    goto(disp(3, 6, 0));  chk("f0_midmode", pixel_out, 12'h603);
    goto(disp(0, 8, 0));  chk("f0_de8", de, 1'b0); chk("f0_vs8", vsync, 1'b1);
    goto(disp(0, 9, 0));  chk("f0_vs9", vsync, 1'b0);
    goto(disp(0, 10, 0)); chk("f0_vs10", vsync, 1'b0);
    goto(disp(0, 11, 0)); chk("f0_vs11", vsync, 1'b1);

    // frame 1, colour bars
    goto(disp(0, 0, 1));  chk("f1_fs", frame_start, 1'b1); chk("f1_fcnt", frame_cnt, 8'd2);
    chk("f1_bar0", pixel_out, 12'hFFF);
    goto(disp(2, 0, 1));  chk("f1_bar1", pixel_out, 12'hFF0);
    goto(disp(4, 0, 1));  chk("f1_bar2", pixel_out, 12'hF0F);
    goto(disp(6, 0, 1));  chk("f1_bar3", pixel_out, 12'hF00);
    goto(disp(14, 0, 1)); chk("f1_bar7", pixel_out, 12'h000);
    mode = 2'd2; zero_pix = 1'b1;

    // frame 2, border over black
    goto(disp(0, 0, 2));  chk("f2_fcnt", frame_cnt, 8'd3);
    goto(disp(5, 0, 2));  chk("f2_row0", pixel_out, 12'hFFF);
    goto(disp(1, 1, 2));  chk("f2_in11", pixel_out, 12'h000);
    goto(disp(5, 2, 2));  chk("f2_in52", pixel_out, 12'h000);
    goto(disp(0, 3, 2));  chk("f2_col0", pixel_out, 12'hFFF);
    goto(disp(15, 3, 2)); chk("f2_colL", pixel_out, 12'hFFF);
    goto(disp(16, 3, 2)); chk("f2_blank", pixel_out, 12'h000);
    goto(disp(5, 7, 2));  chk("f2_rowL", pixel_out, 12'hFFF);
    mode = 2'd3;

    // frame 3, white, with ce held low
    goto(disp(7, 4, 3));
    ce = 1'b0;
    repeat (3) tick();
    chk("hold_pix", pixel_out, 12'hFFF);
    chk("hold_de", de, 1'b1);
    chk("hold_reqx", req_x, 10'd10);
    chk("hold_reqy", req_y, 10'd4);
    goto(disp(16, 4, 3)); chk("f3_blank", pixel_out, 12'h000); chk("f3_de", de, 1'b0);
    goto(disp(0, 5, 3));
    ce = 1'b0;
    repeat (2) tick();
    chk("hold_ls", line_start, 1'b1);
    ce = 1'b1;

    measure(0, 1, per, low, decnt);
    chk("hs_per1", per, 32'(HT)); chk("hs_low1", low, 32'(HS));
    measure(1, 1, per, low, decnt);
    chk("vs_per1", per, 32'(FT)); chk("vs_low1", low, 32'(VS * HT)); chk("de_cnt1", decnt, 32'(HA * VA));
    measure(0, 2, per, low, decnt);
    chk("hs_per2", per, 32'(2 * HT)); chk("hs_low2", low, 32'(2 * HS));
    measure(1, 2, per, low, decnt);
    chk("vs_per2", per, 32'(2 * FT)); chk("vs_low2", low, 32'(2 * VS * HT));
    chk("de_cnt2", decnt, 32'(2 * HA * VA));

    // reset mid-frame while hsync is active: request (22,5), display (19,5)
    t = edges - (edges % FT) + 5 * HT + 22;
    if (t <= edges) t = t + FT;
    goto(t);
    chk("pre_hs", hsync, 1'b0);
    chk("pre_reqx", req_x, 10'd22);
    #2 rst = 1'b0;
    #1;
    chk("mr_hs", hsync, 1'b1);
    chk("mr_de", de, 1'b0);
    chk("mr_pix", pixel_out, 12'h000);
    chk("mr_fcnt", frame_cnt, 8'd0);
    chk("mr_reqx", req_x, 10'd0);
    tick();
    rst = 1'b1; edges = 0;
    tick(); tick();
    chk("mr_e2_fs", frame_start, 1'b0);
    chk("mr_e2_hs", hsync, 1'b1);
    tick();
    chk("mr_e3_fs", frame_start, 1'b1);
    chk("mr_e3_fcnt", frame_cnt, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
